// File: rtl/mdu.sv
// rtl/mdu.sv - iterative multiply/divide unit with HI/LO result registers
// Shift-add multiply and restoring divide share one 2*WIDTH accumulator.
module mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic               neg_q_q, neg_q_d;
  logic               neg_r_q, neg_r_d;
  logic               is_div_q, is_div_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     part, trial;
  logic [2*WIDTH-1:0] mul_next, div_next, prod;
  logic [WIDTH-1:0]   quot, rem;

  always_comb begin
    a_abs = (op[0] & a[WIDTH-1]) ? (WIDTH'(0) - a) : a;
    b_abs = (op[0] & b[WIDTH-1]) ? (WIDTH'(0) - b) : b;

    // Multiply: low half holds the remaining multiplier bits, high half the running sum.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, dvs_q} : {(WIDTH+1){1'b0}});
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: high half is the remainder, low half shifts dividend out and quotient in.
    part  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    trial = part - {1'b0, dvs_q};
    if (!trial[WIDTH]) div_next = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    else               div_next = {part[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

    prod = neg_q_q ? ((2*WIDTH)'(0) - acc_q) : acc_q;
    quot = neg_q_q ? (WIDTH'(0) - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    rem  = neg_r_q ? (WIDTH'(0) - acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    dvs_d    = dvs_q;
    a_raw_d  = a_raw_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    is_div_d = is_div_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (hi_wr) hi_d = wdata;
        if (lo_wr) lo_d = wdata;
        if (start && !flush) begin
          state_d  = S_RUN;
          cnt_d    = '0;
          acc_d    = {{WIDTH{1'b0}}, a_abs};
          dvs_d    = b_abs;
          a_raw_d  = a;
          neg_q_d  = op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_r_d  = op[0] & a[WIDTH-1];
          is_div_d = op[1];
          dz_d     = (b == '0);
        end
      end
      S_RUN: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (!is_div_q) begin
          {hi_d, lo_d} = prod;
        end else if (dz_q) begin
          hi_d = a_raw_q;
          lo_d = {WIDTH{1'b1}};
        end else begin
          hi_d = rem;
          lo_d = quot;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (flush && state_q != S_IDLE) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      dvs_q    <= '0;
      a_raw_q  <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      is_div_q <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      dvs_q    <= dvs_d;
      a_raw_q  <= a_raw_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      is_div_q <= is_div_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/mdu.md
# mdu

Iterative multiply/divide unit with HI/LO result registers for the 5-stage MIPS32 pipeline. It sits beside the ALU in the EX stage and supplies MULT/MULTU/DIV/DIVU, MFHI/MFLO and MTHI/MTLO. It generalises the single-cycle ALU datapath to a parametrised, multi-cycle engine with a start/busy/done handshake and pipeline-flush abort. The hazard logic stalls any MDU instruction or HI/LO read while `busy` is high.

## Interface
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits. Must be ≥ 4 and even.
- `clk`  in  1  clock; everything updates on the rising edge.
- `clr`  in  1  reset, synchronous, active-high.
- `start`  in  1  launch operation; sampled only in IDLE.
- `op`  in  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `a`  in  WIDTH  multiplicand or dividend; captured with `start`.
- `b`  in  WIDTH  multiplier or divisor; captured with `start`.
- `flush`  in  1  abort the in-flight operation (branch or pipeline flush).
- `hi_wr`  in  1  MTHI: `HI <= wdata`.
- `lo_wr`  in  1  MTLO: `LO <= wdata`.
- `wdata`  in  WIDTH  MTHI/MTLO data.
- `busy`  out  1  high in RUN and FIX states (registered).
- `done`  out  1  one-cycle pulse when HI/LO have just been updated by an operation.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
**States**
- IDLE → RUN on `start & ~flush`.
- RUN lasts exactly `WIDTH` cycles, tracked by a `log2(WIDTH)+1`-bit counter. It then moves to FIX.
- FIX → IDLE after one cycle.

**Capture (at `start`)**
- Signed ops (MULT/DIV) store |a| and |b| as unsigned `WIDTH`-bit values.
- They also record `neg_q = a[W-1]^b[W-1]` and `neg_r = a[W-1]`.
- Unsigned ops store the operands as-is, with both sign flags cleared.

**RUN**
- Multiply: radix-2 shift-add, one multiplier bit per cycle. The product accumulator is 2·WIDTH bits.
- Divide: restoring division, one quotient bit per cycle, using a (WIDTH+1)-bit partial remainder.

**FIX**
- Multiply: the product is negated (two's complement over 2·WIDTH bits) if `neg_q`. Then `{HI,LO} <= product`.
- Divide, normal case:
  - `LO <= quotient`, negated if `neg_q`.
  - `HI <= remainder`, negated if `neg_r`.
  - The remainder therefore takes the sign of the dividend, and the quotient truncates toward zero.
- Divide by zero (`b == 0`, either signedness):
  - `LO <= all ones`, `HI <= original a`.
  - Sign correction is suppressed.
- DIV with most-negative dividend and `b = -1`: `LO <= 1 << (WIDTH-1)`, `HI <= 0`. This falls out of the arithmetic and needs no special case.
- `done` = 1 in the cycle after FIX, i.e. the first IDLE cycle.

**HI/LO writes**
- `hi_wr`/`lo_wr` take effect only in IDLE.
- They are ignored while `busy`.
- If `start` and `hi_wr`/`lo_wr` occur in the same cycle, both act: the write lands now and is later overwritten by the result.

**Flush**
- `flush` in any state returns to IDLE at the next edge.
- In-flight state is discarded, HI/LO are unchanged and no `done` pulse is produced.
- `flush` and `start` together in IDLE: `flush` wins and nothing launches.

**Inputs that are ignored**
- `start` while `busy`.
- `a`, `b` and `op` outside the `start` cycle.

## Timing
- Reset values: IDLE, `busy=0`, `done=0`, `hi=0`, `lo=0`, counter = 0, sign flags = 0.
  - `clr` overrides every other input, including mid-operation.
- Cycle-level sequence for a `start` sampled at edge of cycle N:
  - `busy=1` in cycles N+1 … N+WIDTH+1 (RUN for WIDTH cycles, then FIX).
  - HI/LO are updated at the end of cycle N+WIDTH+1.
  - `hi`/`lo` show the new values and `done=1` in cycle N+WIDTH+2.
- Total latency is WIDTH+2 cycles; for WIDTH=32, that is 34.
- Back-to-back: a new `start` is accepted in the `done` cycle. Its `busy` rises in the following cycle.
- `hi`/`lo` are direct register outputs and change only at clock edges.
- A combinational `done` → `start` path is permitted.
- No combinational path from `a`, `b` or `op` to any output.

## Test plan
- **Reset.** Assert `clr` for 2 cycles mid-RUN of a MULTU → `busy=0`, `done=0`, `hi=lo=0`, and the next `start` behaves normally.
- **MULTU / MULT.**
  - WIDTH=32, MULTU `a=0xFFFFFFFF`, `b=0xFFFFFFFF` → after 34 cycles `hi=0xFFFFFFFE`, `lo=0x00000001`, `done` pulses once.
  - MULT `a=-3`, `b=7` → `hi=0xFFFFFFFF`, `lo=0xFFFFFFEB`.
- **DIV / DIVU.**
  - DIV `a=-7`, `b=2` → `lo=0xFFFFFFFD`, `hi=0xFFFFFFFF`.
  - DIVU `a=100`, `b=7` → `lo=14`, `hi=2`.
  - DIV `a=0x80000000`, `b=0xFFFFFFFF` → `lo=0x80000000`, `hi=0`.
- **Divide by zero.** DIVU `a=0x1234`, `b=0` → `lo=0xFFFFFFFF`, `hi=0x1234`. DIV `a=-5`, `b=0` → `lo=0xFFFFFFFF`, `hi=0xFFFFFFFB`.
- **Flush and ignored inputs.**
  - Preload `hi=0xAA`, `lo=0x55` via MTHI/MTLO.
  - Start MULTU 3×4 and assert `flush` in cycle N+10 → `busy=0` next cycle, no `done`, `hi=0xAA`, `lo=0x55`.
  - `start` during `busy` → ignored.
  - `hi_wr` during `busy` → ignored.
- **Parametrisation and back-to-back.** WIDTH=8: MULT `a=0x80`, `b=0x80` → `{hi,lo}=0x4000` after 10 cycles. A DIVU 200/9 issued in the `done` cycle → `lo=22`, `hi=2`, 10 cycles later.
